// File: rtl/tug_pkg.sv
// rtl/tug_pkg.sv - shared types and helpers for the tug-of-war match referee
package tug_pkg;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    ROUND_END = 2'd1,
    MATCH_END = 2'd2
  } state_t;

  typedef enum logic {
    SIDE_L = 1'b0,
    SIDE_R = 1'b1
  } side_t;

  function automatic int center_idx(input int field_w);
    return (field_w - 1) / 2;
  endfunction

endpackage

// File: rtl/tug_position.sv
// rtl/tug_position.sv - light position counter with centre load, edge flags and one-hot decode
module tug_position
  import tug_pkg::*;
#(
  parameter int FIELD_W = 9,
  parameter int PW      = $clog2(FIELD_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_inc,
  input  logic               i_dec,
  input  logic               i_load_c,
  output logic [PW-1:0]      o_pos,
  output logic               o_at_left,
  output logic               o_at_right,
  output logic [FIELD_W-1:0] o_onehot
);

  localparam logic [PW-1:0] CENTER   = PW'(center_idx(FIELD_W));
  localparam logic [PW-1:0] LEFT_IDX = PW'(FIELD_W - 1);

  logic [PW-1:0] r_pos;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pos <= CENTER;
    end else if (i_load_c) begin
      r_pos <= CENTER;
    end else if (i_inc) begin
      r_pos <= r_pos + 1'b1;
    end else if (i_dec) begin
      r_pos <= r_pos - 1'b1;
    end
  end

  assign o_pos      = r_pos;
  assign o_at_left  = (r_pos == LEFT_IDX);
  assign o_at_right = (r_pos == '0);
  assign o_onehot   = FIELD_W'(1) << r_pos;

endmodule

// File: rtl/tug_match_referee.sv
// rtl/tug_match_referee.sv - round/match referee FSM with scoring; WIN_HOLD_EN adds a timed round-end hold
module tug_match_referee
  import tug_pkg::*;
#(
  parameter int FIELD_W       = 9,
  parameter int WINS_TO_MATCH = 7,
  parameter int SCORE_W       = 3,
  parameter int HOLD_CYCLES   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               l_press,
  input  logic               r_press,
  output logic [FIELD_W-1:0] field,
  output logic               round_win_l,
  output logic               round_win_r,
  output logic               round_restart,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               match_over,
  output logic               match_winner
);

  localparam int PW = $clog2(FIELD_W);
  localparam logic [SCORE_W-1:0] WIN_TARGET = SCORE_W'(WINS_TO_MATCH);

  if ((FIELD_W % 2) == 0 || FIELD_W < 3 || WINS_TO_MATCH < 1 ||
      WINS_TO_MATCH > (2 ** SCORE_W) - 1 || HOLD_CYCLES < 1) begin : g_param_bad
    $error("tug_match_referee: illegal parameter combination");
  end

  state_t             r_state;
  state_t             w_next;
  side_t              r_winner;
  logic [SCORE_W-1:0] r_score_l;
  logic [SCORE_W-1:0] r_score_r;
  logic               r_win_l;
  logic               r_win_r;
  logic               r_restart;

  logic               w_l_only;
  logic               w_r_only;
  logic               w_win_l;
  logic               w_win_r;
  logic               w_inc;
  logic               w_dec;
  logic               w_load_c;
  logic               w_hold_done;
  logic               w_at_left;
  logic               w_at_right;
  logic [PW-1:0]      w_pos;
  logic [FIELD_W-1:0] w_onehot;
  logic [SCORE_W-1:0] w_score_l_inc;
  logic [SCORE_W-1:0] w_score_r_inc;

  assign w_l_only      = l_press & ~r_press;
  assign w_r_only      = r_press & ~l_press;
  assign w_score_l_inc = r_score_l + 1'b1;
  assign w_score_r_inc = r_score_r + 1'b1;
  assign w_inc         = (r_state == PLAY) & w_l_only & ~w_at_left;
  assign w_dec         = (r_state == PLAY) & w_r_only & ~w_at_right;
  assign w_load_c      = (r_state == ROUND_END) & (w_next == PLAY);

  tug_position #(
    .FIELD_W (FIELD_W),
    .PW      (PW)
  ) u_position (
    .clk        (clk),
    .reset      (reset),
    .i_inc      (w_inc),
    .i_dec      (w_dec),
    .i_load_c   (w_load_c),
    .o_pos      (w_pos),
    .o_at_left  (w_at_left),
    .o_at_right (w_at_right),
    .o_onehot   (w_onehot)
  );

`ifdef WIN_HOLD_EN
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  logic [HW-1:0] r_hold;

  // Loaded on the winning edge so ROUND_END spans exactly HOLD_CYCLES cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold <= '0;
    end else if (r_state == PLAY && w_next == ROUND_END) begin
      r_hold <= HW'(HOLD_CYCLES - 1);
    end else if (r_state == ROUND_END && r_hold != '0) begin
      r_hold <= r_hold - 1'b1;
    end
  end

  assign w_hold_done = (r_hold == '0);
`else
  assign w_hold_done = 1'b1;
`endif

  always_comb begin
    w_next  = r_state;
    w_win_l = 1'b0;
    w_win_r = 1'b0;
    case (r_state)
      PLAY: begin
        if (w_l_only && w_at_left) begin
          w_win_l = 1'b1;
          w_next  = (w_score_l_inc == WIN_TARGET) ? MATCH_END : ROUND_END;
        end else if (w_r_only && w_at_right) begin
          w_win_r = 1'b1;
          w_next  = (w_score_r_inc == WIN_TARGET) ? MATCH_END : ROUND_END;
        end
      end
      ROUND_END: begin
        if (w_hold_done) begin
          w_next = PLAY;
        end
      end
      MATCH_END: w_next = MATCH_END;
      default:   w_next = PLAY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= PLAY;
      r_score_l <= '0;
      r_score_r <= '0;
      r_win_l   <= 1'b0;
      r_win_r   <= 1'b0;
      r_restart <= 1'b0;
      r_winner  <= SIDE_L;
    end else begin
      r_state   <= w_next;
      r_win_l   <= w_win_l;
      r_win_r   <= w_win_r;
      r_restart <= w_load_c;
      if (w_win_l) begin
        r_score_l <= w_score_l_inc;
      end
      if (w_win_r) begin
        r_score_r <= w_score_r_inc;
      end
      if (r_state != MATCH_END && w_next == MATCH_END) begin
        r_winner <= w_win_r ? SIDE_R : SIDE_L;
      end
    end
  end

  // The position register still sits on the winning edge after a win.
  always_comb begin
    field = '0;
    case (r_state)
      PLAY:      field = w_onehot;
      MATCH_END: field = w_onehot;
`ifdef WIN_HOLD_EN
      ROUND_END: field = w_onehot;
`else
      ROUND_END: field = '0;
`endif
      default:   field = '0;
    endcase
  end

  assign round_win_l   = r_win_l;
  assign round_win_r   = r_win_r;
  assign round_restart = r_restart;
  assign score_l       = r_score_l;
  assign score_r       = r_score_r;
  assign match_over    = (r_state == MATCH_END);
  assign match_winner  = r_winner;

endmodule

// File: tb/tb_tug_match_referee.sv
// tb/tb_tug_match_referee.sv - directed plus random bench for tug_match_referee against a behavioural model
module tb_tug_match_referee;

  localparam int FW  = 9;
  localparam int W2M = 2;
  localparam int SW  = 3;
  localparam int HC  = 4;
  localparam int C   = (FW - 1) / 2;
`ifdef WIN_HOLD_EN
  localparam int GAP = HC;
`else
  localparam int GAP = 1;
`endif

  logic          clk;
  logic          reset;
  logic          l_press;
  logic          r_press;
  logic [FW-1:0] field;
  logic          round_win_l;
  logic          round_win_r;
  logic          round_restart;
  logic [SW-1:0] score_l;
  logic [SW-1:0] score_r;
  logic          match_over;
  logic          match_winner;

  int total;
  int bad;

  int m_pos;
  int m_sl;
  int m_sr;
  int m_gap;
  int m_over;
  int m_winner;
  int m_wl;
  int m_wr;
  int m_restart;

  tug_match_referee #(
    .FIELD_W       (FW),
    .WINS_TO_MATCH (W2M),
    .SCORE_W       (SW),
    .HOLD_CYCLES   (HC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .l_press       (l_press),
    .r_press       (r_press),
    .field         (field),
    .round_win_l   (round_win_l),
    .round_win_r   (round_win_r),
    .round_restart (round_restart),
    .score_l       (score_l),
    .score_r       (score_r),
    .match_over    (match_over),
    .match_winner  (match_winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = C; m_sl = 0; m_sr = 0; m_gap = 0;
    m_over = 0; m_winner = 0; m_wl = 0; m_wr = 0; m_restart = 0;
  endtask

  // One rising edge of the game rules, in plain integer terms.
  task automatic model_step(input logic l, input logic r);
    m_wl = 0; m_wr = 0; m_restart = 0;
    if (m_over != 0) begin
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) begin
        m_pos = C;
        m_restart = 1;
      end
    end else if (l && !r) begin
      if (m_pos == FW - 1) begin
        m_sl++; m_wl = 1;
        if (m_sl == W2M) begin m_over = 1; m_winner = 0; end
        else m_gap = GAP;
      end else m_pos++;
    end else if (r && !l) begin
      if (m_pos == 0) begin
        m_sr++; m_wr = 1;
        if (m_sr == W2M) begin m_over = 1; m_winner = 1; end
        else m_gap = GAP;
      end else m_pos--;
    end
  endtask

  task automatic check_all(input string tag);
    int ef;
`ifdef WIN_HOLD_EN
    ef = 1 << m_pos;
`else
    ef = (m_gap > 0 && m_over == 0) ? 0 : (1 << m_pos);
`endif
    chk({tag, "_field"}, 32'(field), 32'(ef));
    chk({tag, "_win_l"}, 32'(round_win_l), 32'(m_wl));
    chk({tag, "_win_r"}, 32'(round_win_r), 32'(m_wr));
    chk({tag, "_restart"}, 32'(round_restart), 32'(m_restart));
    chk({tag, "_score_l"}, 32'(score_l), 32'(m_sl));
    chk({tag, "_score_r"}, 32'(score_r), 32'(m_sr));
    chk({tag, "_over"}, 32'(match_over), 32'(m_over));
    if (m_over != 0) chk({tag, "_winner"}, 32'(match_winner), 32'(m_winner));
  endtask

  // Called at a falling edge; drives presses, takes one rising edge, returns at the next falling edge.
  task automatic step(input logic l, input logic r);
    l_press = l;
    r_press = r;
    @(posedge clk);
    model_step(l, r);
    @(negedge clk);
    l_press = 1'b0;
    r_press = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1 model_reset();
    check_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic dir;
    total = 0;
    bad = 0;
    reset = 1'b1;
    l_press = 1'b0;
    r_press = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    chk("reset_field_const", 32'(field), 32'h010);
    chk("reset_winner", 32'(match_winner), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      check_all("t1_walk");
    end
    chk("t1_edge_const", 32'(field), 32'h100);
    step(1'b1, 1'b0);
    check_all("t1_win");
    chk("t1_win_pulse_const", 32'(round_win_l), 32'h1);
    for (int i = 0; i < GAP; i++) begin
      step(1'b0, 1'b0);
      check_all("t1_gap");
    end
    chk("t1_restart_const", 32'(round_restart), 32'h1);
    chk("t1_centre_const", 32'(field), 32'h010);

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      check_all("t2_both");
    end

    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 5; i++) begin
        step(1'b0, 1'b1);
        check_all("t3_right");
      end
      if (w == 0) begin
        for (int i = 0; i < GAP; i++) begin
          step(1'b1, 1'b0);
          check_all("t5_ignored");
        end
        chk("t5_centre_const", 32'(field), 32'h010);
      end
    end
    chk("t3_over_const", 32'(match_over), 32'h1);
    chk("t3_winner_const", 32'(match_winner), 32'h1);
    chk("t3_field_const", 32'(field), 32'h001);
    for (int i = 0; i < 4; i++) begin
      step(1'(i), 1'(~i));
      check_all("t3_frozen");
    end
    async_reset("t3_reset");

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    for (int i = 0; i < GAP; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    check_all("t4_pre");
    chk("t4_pos7_const", 32'(field), 32'h080);
    async_reset("t4_async");
    chk("t4_field_const", 32'(field), 32'h010);
    chk("t4_score_const", 32'(score_l), 32'h0);

    dir = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (($urandom % 40) == 0) dir = ~dir;
      if (m_over != 0 && ($urandom % 6) == 0) begin
        async_reset("rnd_reset");
      end else begin
        step(1'(($urandom % 100) < (dir ? 70 : 30)),
             1'(($urandom % 100) < (dir ? 30 : 70)));
        check_all("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
